// File: rtl/q_updater.sv
// Q-learning update stage: owns the Q8.8 Q-table, serves one registered row per cycle
// to the policy generator and applies one Q(s,a) update per six-cycle transaction.
module q_updater #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [3:0]         action,
    input  logic [15:0]        reward,
    input  logic [STATE_W-1:0] next_state,
    input  logic [15:0]        alpha,
    input  logic [15:0]        gamma,
    input  logic [STATE_W-1:0] rd_state,
    output logic [63:0]        q_values,
    output logic               done,
    output logic               err
);
    localparam int ROWS = 1 << STATE_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_MAXQ   = 3'd2;
    localparam logic [2:0] S_TARGET = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_WRITE  = 3'd5;

    logic [2:0]          state;
    logic [STATE_W-1:0]  s_r;
    logic [STATE_W-1:0]  ns_r;
    logic [3:0]          act_r;
    logic signed [15:0]  r_r;
    logic [15:0]         alpha_r;
    logic [15:0]         gamma_r;
    logic [1:0]          idx_r;
    logic                inv_r;
    logic signed [15:0]  q_sa;
    logic signed [15:0]  qn [4];
    logic signed [15:0]  maxq;
    logic signed [15:0]  target;
    logic signed [15:0]  step;
    logic signed [15:0]  q_table [ROWS][4];

    function automatic logic signed [31:0] sx32(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767)
            return 16'sh7FFF;
        else if (v < -32'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // One-hot action decode; anything else flags the request invalid.
    logic [1:0] idx_dec;
    logic       inv_dec;
    always_comb begin
        // NOTE: every signal gets a default before the case, so no latch is inferred.
        idx_dec = 2'd0;
        inv_dec = 1'b0;
        case (act_r)
            4'b0001: idx_dec = 2'd0;
            4'b0010: idx_dec = 2'd1;
            4'b0100: idx_dec = 2'd2;
            4'b1000: idx_dec = 2'd3;
            default: inv_dec = 1'b1;
        endcase
    end

    logic signed [15:0] max01, max23, max_all;
    logic signed [31:0] g_prod, a_prod;
    logic signed [15:0] target_next, diff, step_next, q_new;

    // alpha/gamma are zero-extended so the 32-bit signed products never overflow.
    assign max01       = (qn[0] > qn[1]) ? qn[0] : qn[1];
    assign max23       = (qn[2] > qn[3]) ? qn[2] : qn[3];
    assign max_all     = (max01 > max23) ? max01 : max23;
    assign g_prod      = $signed({16'd0, gamma_r}) * sx32(maxq);
    assign target_next = sat16(sx32(r_r) + (g_prod >>> 8));
    assign diff        = sat16(sx32(target) - sx32(q_sa));
    assign a_prod      = $signed({16'd0, alpha_r}) * sx32(diff);
    assign step_next   = sat16(a_prod >>> 8);
    assign q_new       = sat16(sx32(q_sa) + sx32(step));

    assign upd_ready = (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            s_r      <= '0;
            ns_r     <= '0;
            act_r    <= '0;
            r_r      <= '0;
            alpha_r  <= '0;
            gamma_r  <= '0;
            idx_r    <= '0;
            inv_r    <= 1'b0;
            q_sa     <= '0;
            maxq     <= '0;
            target   <= '0;
            step     <= '0;
            q_values <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            // NOTE: the table is flop-based and must clear on reset, so it is reset here
            // like any other register rather than left to power-up contents.
            for (int i = 0; i < 4; i++) qn[i] <= '0;
            for (int r = 0; r < ROWS; r++)
                for (int a = 0; a < 4; a++) q_table[r][a] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read below sees
            // the pre-edge value (this is what gives old-data on a read/write collision).
            done <= 1'b0;
            err  <= 1'b0;
            for (int i = 0; i < 4; i++) q_values[16*i +: 16] <= q_table[rd_state][i];

            case (state)
                S_IDLE: if (upd_valid) begin
                    s_r     <= cur_state;
                    ns_r    <= next_state;
                    act_r   <= action;
                    r_r     <= reward;
                    alpha_r <= alpha;
                    gamma_r <= gamma;
                    state   <= S_LOAD;
                end
                S_LOAD: begin
                    idx_r <= idx_dec;
                    inv_r <= inv_dec;
                    q_sa  <= q_table[s_r][idx_dec];
                    for (int i = 0; i < 4; i++) qn[i] <= q_table[ns_r][i];
                    state <= S_MAXQ;
                end
                S_MAXQ: begin
                    maxq  <= max_all;
                    state <= S_TARGET;
                end
                S_TARGET: begin
                    target <= target_next;
                    state  <= S_UPDATE;
                end
                S_UPDATE: begin
                    step  <= step_next;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (!inv_r) q_table[s_r][idx_r] <= q_new;
                    done  <= 1'b1;
                    err   <= inv_r;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_q_updater.sv
// Directed bench for q_updater: hand-computed Q8.8 updates, timing of done/ready,
// invalid actions, busy-time requests and mid-transaction reset.
module tb_q_updater;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [3:0]  cur_state = '0;
    logic [3:0]  action = '0;
    logic [15:0] reward = '0;
    logic [3:0]  next_state = '0;
    logic [15:0] alpha = '0;
    logic [15:0] gamma = '0;
    logic [3:0]  rd_state = '0;
    logic [63:0] q_values;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] q_at_done;
    logic [63:0] q_after;

    q_updater #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .cur_state  (cur_state),
        .action     (action),
        .reward     (reward),
        .next_state (next_state),
        .alpha      (alpha),
        .gamma      (gamma),
        .rd_state   (rd_state),
        .q_values   (q_values),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic [3:0] a, input logic [15:0] r,
                         input logic [3:0] ns, input logic [15:0] al, input logic [15:0] ga);
        cur_state  = s;
        action     = a;
        reward     = r;
        next_state = ns;
        alpha      = al;
        gamma      = ga;
    endtask

    // Returns just after the transfer edge k.
    task automatic send(input string tag, input logic [3:0] s, input logic [3:0] a,
                        input logic [15:0] r, input logic [3:0] ns,
                        input logic [15:0] al, input logic [15:0] ga);
        int w = 0;
        drive(s, a, r, ns, al, ga);
        upd_valid = 1'b1;
        while (!upd_ready && w < 20) begin
            tick();
            w++;
        end
        if (!upd_ready) check({tag, "_ready_timeout"}, upd_ready, 1'b1);
        tick();
        upd_valid = 1'b0;
    endtask

    // done must be seen just after edge k+5, then drop one cycle later.
    task automatic wait_done(input string tag, input logic exp_err);
        int n = 0;
        while (n < 20) begin
            tick();
            n++;
            if (done) break;
        end
        check({tag, "_latency"}, 64'(n), 64'd5);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_ready_at_done"}, upd_ready, 1'b1);
        q_at_done = q_values;
        tick();
        q_after = q_values;
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    task automatic check_row(input string tag, input logic [3:0] row, input logic [63:0] exp);
        rd_state = row;
        tick();
        check(tag, q_values, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_done;

        // Reset state and zeroed table
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", upd_ready, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        for (int i = 0; i < 16; i++) check_row($sformatf("rst_row%0d", i), 4'(i), 64'd0);

        // Basic update, with read/write collision on row 0
        rd_state = 4'd0;
        send("u1", 4'd0, 4'b0001, 16'h0100, 4'd1, 16'h0080, 16'h00E6);
        wait_done("u1", 1'b0);
        check("u1_collision_old", q_at_done, 64'd0);
        check("u1_collision_new", q_after, 64'h0000_0000_0000_0080);

        send("u2", 4'd0, 4'b0001, 16'h0100, 4'd1, 16'h0080, 16'h00E6);
        wait_done("u2", 1'b0);
        check_row("u2_row0", 4'd0, 64'h0000_0000_0000_00C0);

        // Discount chain
        send("d1", 4'd1, 4'b0100, 16'h0200, 4'd2, 16'h0100, 16'h0000);
        wait_done("d1", 1'b0);
        check_row("d1_row1", 4'd1, 64'h0000_0200_0000_0000);
        send("d2", 4'd0, 4'b0010, 16'h0000, 4'd1, 16'h0100, 16'h0080);
        wait_done("d2", 1'b0);
        check_row("d2_row0", 4'd0, 64'h0000_0000_0100_00C0);

        // Negative reward, then truncation toward negative infinity (-128 >>> 8 = -1)
        send("n1", 4'd2, 4'b0001, 16'hFF00, 4'd3, 16'h0080, 16'h0000);
        wait_done("n1", 1'b0);
        check_row("n1_row2", 4'd2, 64'h0000_0000_0000_FF80);
        send("n2", 4'd2, 4'b0010, 16'hFFFF, 4'd3, 16'h0080, 16'h0000);
        wait_done("n2", 1'b0);
        check_row("n2_row2", 4'd2, 64'h0000_0000_FFFF_FF80);

        // Positive saturation: maxQ(row1)=0x0200
        send("sat", 4'd3, 4'b0001, 16'h7FFF, 4'd1, 16'h0100, 16'h0100);
        wait_done("sat", 1'b0);
        check_row("sat_row3", 4'd3, 64'h0000_0000_0000_7FFF);

        // Invalid action: err with done, no write
        send("inv", 4'd0, 4'b0011, 16'h0100, 4'd1, 16'h0100, 16'h0100);
        wait_done("inv", 1'b1);
        check_row("inv_row0", 4'd0, 64'h0000_0000_0100_00C0);
        check_row("inv_row1", 4'd1, 64'h0000_0200_0000_0000);
        check_row("inv_row2", 4'd2, 64'h0000_0000_FFFF_FF80);
        check_row("inv_row3", 4'd3, 64'h0000_0000_0000_7FFF);

        // upd_valid held through busy with changing fields
        drive(4'd4, 4'b0001, 16'h0100, 4'd5, 16'h0100, 16'h0000);
        upd_valid = 1'b1;
        tick();                                   // edge k: request A accepted
        check("busy_ready_load", upd_ready, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            drive(4'd6, 4'(1 << (i - 1)), 16'h7000 + 16'(i), 4'd6, 16'h0100, 16'h0100);
            tick();                               // edges k+1..k+4
            check($sformatf("busy_ready_%0d", i), upd_ready, 1'b0);
        end
        drive(4'd7, 4'b0010, 16'h0040, 4'd0, 16'h0100, 16'h0000);
        tick();                                   // edge k+5: A written
        check("busy_done_a", done, 1'b1);
        check("busy_ready_a", upd_ready, 1'b1);
        tick();                                   // edge k+6: request B accepted
        upd_valid = 1'b0;
        check("busy_accept_k6", upd_ready, 1'b0);
        wait_done("busy_b", 1'b0);
        check_row("busy_row4", 4'd4, 64'h0000_0000_0000_0100);
        check_row("busy_row6", 4'd6, 64'd0);
        check_row("busy_row7", 4'd7, 64'h0000_0000_0040_0000);

        // Reset while in UPDATE aborts the transaction and clears the table
        send("rst_mid", 4'd8, 4'b0001, 16'h0100, 4'd9, 16'h0100, 16'h0000);
        tick();
        tick();
        tick();                                   // after edge k+3: UPDATE
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", upd_ready, 1'b1);
        check("rst_mid_q", q_values, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("rst_mid_no_done", seen_done, 1'b0);
        check("rst_mid_ready_after", upd_ready, 1'b1);
        for (int i = 0; i < 16; i++) check_row($sformatf("rst_mid_row%0d", i), 4'(i), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
